// File: rtl/whack_pkg.sv
// Shared types and BCD/popcount helpers for the whack-a-mole scorer.
// Helpers operate on a fixed 4-digit (16-bit) BCD vector; callers pass the live digit count.
package whack_pkg;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
  localparam int unsigned MAX_DIGITS    = 4;
  localparam int unsigned MAX_CH        = 16;

  function automatic logic [4:0] popcount(input logic [MAX_CH-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  // Adds n (0..16) to the low ndig digits; bit 16 is the carry out of the top live digit.
  function automatic logic [16:0] bcd_add(input logic [15:0] d, input logic [4:0] n,
                                          input int unsigned ndig);
    logic [15:0] r;
    logic [4:0]  c;
    logic [4:0]  s;
    r = '0;
    c = n;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (i < ndig) begin
        s = 5'(d[i*BCD_DIGIT_W +: BCD_DIGIT_W]) + c;
        if (s > 5'(BCD_MAX_DIGIT)) begin
          c = 5'(s / 5'd10);
          r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'(s % 5'd10);
        end else begin
          c = '0;
          r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'(s);
        end
      end
    end
    return {|c, r};
  endfunction

  // Subtracts n from the low ndig digits, saturating at zero instead of wrapping.
  function automatic logic [15:0] bcd_sub_sat(input logic [15:0] d, input logic [4:0] n,
                                              input int unsigned ndig);
    logic [15:0] r;
    int          b;
    int          v;
    r = '0;
    b = int'(n);
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (i < ndig) begin
        v = int'(d[i*BCD_DIGIT_W +: BCD_DIGIT_W]) - b;
        b = 0;
        if (v < 0) begin
          b = (9 - v) / 10;
          v = v + 10 * b;
        end
        r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'(v);
      end
    end
    if (b != 0) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/whack_edge_sampler.sv
// Down-sampling tick divider plus per-channel 3-deep switch history.
// edge_c flags a 0->1 transition between the two oldest samples; tick_d marks the cycle after a tick.
module whack_edge_sampler #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned DS_DIV = 131072,
  parameter int unsigned CNT_W  = $clog2(DS_DIV)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] switch,
  output logic [N_CH-1:0] edge_c,
  output logic            tick_d
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  samp2_q, samp2_d;
  logic [N_CH-1:0]  samp1_q, samp1_d;
  logic [N_CH-1:0]  samp0_q, samp0_d;
  logic             tick_d_q, tick_d_d;
  logic             tick;

  always_comb begin
    tick     = (cnt_q == CNT_W'(DS_DIV - 1));
    cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
    tick_d_d = tick;
    samp2_d  = samp2_q;
    samp1_d  = samp1_q;
    samp0_d  = samp0_q;
    if (tick) begin
      samp2_d = switch;
      samp1_d = samp2_q;
      samp0_d = samp1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      samp2_q  <= '0;
      samp1_q  <= '0;
      samp0_q  <= '0;
      tick_d_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      samp2_q  <= samp2_d;
      samp1_q  <= samp1_d;
      samp0_q  <= samp0_d;
      tick_d_q <= tick_d_d;
    end
  end

  assign edge_c = samp1_q & ~samp0_q;
  assign tick_d = tick_d_q;

endmodule

// File: rtl/whack_scorer.sv
// Whack-a-mole scoring engine: qualifies sampled switch edges against mole LEDs into a BCD score.
// Optional miss penalty (and miss_pulse port) enabled by defining WHACK_MISS_PENALTY_EN.
module whack_scorer
  import whack_pkg::*;
#(
  parameter int unsigned N_CH     = 8,
  parameter int unsigned N_DIGITS = 2,
  parameter int unsigned DS_DIV   = 131072,
  parameter int unsigned CNT_W    = $clog2(DS_DIV)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pause,
  input  logic                        clear,
  input  logic [N_CH-1:0]             switch,
  input  logic [N_CH-1:0]             led,
  output logic [4*N_DIGITS-1:0]       score_bcd,
  output logic                        hit_pulse,
  output logic [N_CH-1:0]             hit_vec,
`ifdef WHACK_MISS_PENALTY_EN
  output logic                        miss_pulse,
`endif
  output logic                        overflow
);

  localparam int unsigned SCORE_W = BCD_DIGIT_W * N_DIGITS;

  logic [N_CH-1:0]    edge_c;
  logic               tick_d;
  logic [N_CH-1:0]    hit_q, hit_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               hit_pulse_q, hit_pulse_d;
  logic [N_CH-1:0]    hit_vec_q, hit_vec_d;
  logic               overflow_q, overflow_d;
  logic [4:0]         n_hit;
  logic [16:0]        add_res;

  whack_edge_sampler #(
    .N_CH   (N_CH),
    .DS_DIV (DS_DIV),
    .CNT_W  (CNT_W)
  ) u_sampler (
    .clk    (clk),
    .rst    (rst),
    .switch (switch),
    .edge_c (edge_c),
    .tick_d (tick_d)
  );

`ifdef WHACK_MISS_PENALTY_EN
  logic [N_CH-1:0] miss_q, miss_d;
  logic            miss_pulse_q, miss_pulse_d;
  logic [4:0]      n_miss;

  // Net change is applied as one add or one saturating subtract so a wrap never mixes with a borrow.
  always_comb begin
    miss_d       = '0;
    if (tick_d) miss_d = edge_c & ~led & {N_CH{~pause}};
    n_hit        = popcount(16'(hit_q));
    n_miss       = popcount(16'(miss_q));
    add_res      = bcd_add(16'(score_q), 5'(n_hit - n_miss), N_DIGITS);
    score_d      = score_q;
    overflow_d   = overflow_q;
    hit_d        = '0;
    if (tick_d) hit_d = edge_c & led & {N_CH{~pause}};
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
    hit_vec_d    = hit_q;
    if (clear) begin
      score_d    = '0;
      overflow_d = 1'b0;
      hit_vec_d  = '0;
    end else if (!pause) begin
      hit_pulse_d  = (n_hit != 5'd0);
      miss_pulse_d = (n_miss != 5'd0);
      if (n_hit >= n_miss) begin
        score_d = SCORE_W'(add_res);
        if (add_res[16]) overflow_d = 1'b1;
      end else begin
        score_d = SCORE_W'(bcd_sub_sat(16'(score_q), 5'(n_miss - n_hit), N_DIGITS));
      end
    end else begin
      hit_vec_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_q       <= '0;
      miss_pulse_q <= 1'b0;
    end else begin
      miss_q       <= miss_d;
      miss_pulse_q <= miss_pulse_d;
    end
  end

  assign miss_pulse = miss_pulse_q;
`else
  always_comb begin
    n_hit       = popcount(16'(hit_q));
    add_res     = bcd_add(16'(score_q), n_hit, N_DIGITS);
    score_d     = score_q;
    overflow_d  = overflow_q;
    hit_d       = '0;
    if (tick_d) hit_d = edge_c & led & {N_CH{~pause}};
    hit_pulse_d = 1'b0;
    hit_vec_d   = hit_q;
    if (clear) begin
      score_d    = '0;
      overflow_d = 1'b0;
      hit_vec_d  = '0;
    end else if (!pause) begin
      hit_pulse_d = (n_hit != 5'd0);
      score_d     = SCORE_W'(add_res);
      if (add_res[16]) overflow_d = 1'b1;
    end else begin
      hit_vec_d = '0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q       <= '0;
      score_q     <= '0;
      hit_pulse_q <= 1'b0;
      hit_vec_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      hit_q       <= hit_d;
      score_q     <= score_d;
      hit_pulse_q <= hit_pulse_d;
      hit_vec_q   <= hit_vec_d;
      overflow_q  <= overflow_d;
    end
  end

  assign score_bcd = score_q;
  assign hit_pulse = hit_pulse_q;
  assign hit_vec   = hit_vec_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_whack_scorer.sv
// Directed self-checking bench for whack_scorer (N_CH=8, N_DIGITS=2, DS_DIV=4).
module tb_whack_scorer;

  logic       clk = 1'b0;
  logic       rst;
  logic       pause;
  logic       clear;
  logic [7:0] switch;
  logic [7:0] led;
  logic [7:0] score_bcd;
  logic       hit_pulse;
  logic [7:0] hit_vec;
  logic       overflow;
`ifdef WHACK_MISS_PENALTY_EN
  logic       miss_pulse;
  int         miss_pulses = 0;
`endif

  int         vectors     = 0;
  int         miscompares = 0;
  int         pulses      = 0;
  logic [7:0] last_vec    = '0;

  whack_scorer #(
    .N_CH     (8),
    .N_DIGITS (2),
    .DS_DIV   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pause     (pause),
    .clear     (clear),
    .switch    (switch),
    .led       (led),
    .score_bcd (score_bcd),
    .hit_pulse (hit_pulse),
    .hit_vec   (hit_vec),
`ifdef WHACK_MISS_PENALTY_EN
    .miss_pulse(miss_pulse),
`endif
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Pulse monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (hit_pulse) begin
      pulses   <= pulses + 1;
      last_vec <= hit_vec;
    end
`ifdef WHACK_MISS_PENALTY_EN
    if (miss_pulse) miss_pulses <= miss_pulses + 1;
`endif
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise a switch pattern, let it register, then release and let the history return to zero.
  task automatic press(input logic [7:0] pattern);
    switch = pattern;
    run(20);
    switch = 8'h00;
    run(20);
  endtask

  initial begin
    rst = 1'b1; pause = 1'b0; clear = 1'b0; switch = 8'h00; led = 8'h00;
    run(3);
    check("rst_score", 32'(score_bcd), 32'h00);
    check("rst_hit_pulse", 32'(hit_pulse), 32'h0);
    check("rst_hit_vec", 32'(hit_vec), 32'h00);
    check("rst_overflow", 32'(overflow), 32'h0);

    rst = 1'b0;
    pulses = 0;
    run(20);
    check("idle_pulses", 32'(pulses), 32'd0);
    check("idle_score", 32'(score_bcd), 32'h00);

    // Single hit, held for several ticks
    led = 8'h04;
    pulses = 0;
    switch = 8'h04;
    run(20);
    check("single_pulses", 32'(pulses), 32'd1);
    check("single_vec", 32'(last_vec), 32'h04);
    check("single_score", 32'(score_bcd), 32'h01);
    run(20);
    check("held_pulses", 32'(pulses), 32'd1);
    check("held_score", 32'(score_bcd), 32'h01);
    switch = 8'h00;
    run(20);

    // Seven simultaneous hits take 01 -> 08, then three more carry into the tens digit
    led = 8'hFF;
    press(8'h7F);
    check("seven_score", 32'(score_bcd), 32'h08);
    pulses = 0;
    press(8'h07);
    check("simul_pulses", 32'(pulses), 32'd1);
    check("simul_vec", 32'(last_vec), 32'h07);
    check("simul_score", 32'(score_bcd), 32'h11);

    // Climb to 98: ten updates of +8 then +7
    for (int i = 0; i < 10; i++) press(8'hFF);
    check("ninety_one", 32'(score_bcd), 32'h91);
    press(8'h7F);
    check("ninety_eight", 32'(score_bcd), 32'h98);
    check("pre_wrap_ovf", 32'(overflow), 32'h0);
    press(8'h03);
    check("wrap_score", 32'(score_bcd), 32'h00);
    check("wrap_overflow", 32'(overflow), 32'h1);
    press(8'h01);
    check("post_wrap_score", 32'(score_bcd), 32'h01);
    check("ovf_sticky", 32'(overflow), 32'h1);
    clear = 1'b1;
    run(1);
    clear = 1'b0;
    check("clear_overflow", 32'(overflow), 32'h0);
    check("clear_score", 32'(score_bcd), 32'h00);

    // Pause over the edge, release while still held: no hit
    pulses = 0;
    pause = 1'b1;
    switch = 8'h01;
    run(12);
    pause = 1'b0;
    run(20);
    check("pause_pulses", 32'(pulses), 32'd0);
    check("pause_score", 32'(score_bcd), 32'h00);
    switch = 8'h00;
    run(20);

    // Rising switch with its mole down
    led = 8'h00;
    pulses = 0;
`ifdef WHACK_MISS_PENALTY_EN
    miss_pulses = 0;
`endif
    press(8'h20);
    check("miss_pulses_hit", 32'(pulses), 32'd0);
    check("miss_score_zero", 32'(score_bcd), 32'h00);
`ifdef WHACK_MISS_PENALTY_EN
    check("miss_pulse_cnt", 32'(miss_pulses), 32'd1);
`endif
    led = 8'hFF;
    press(8'hFF);
    press(8'h03);
    check("ten_score", 32'(score_bcd), 32'h10);
    led = 8'h00;
    press(8'h20);
`ifdef WHACK_MISS_PENALTY_EN
    check("miss_sub_score", 32'(score_bcd), 32'h09);
    check("miss_pulse_cnt2", 32'(miss_pulses), 32'd2);
`else
    check("miss_ignored_score", 32'(score_bcd), 32'h10);
`endif

    // Async reset mid-run clears everything
    rst = 1'b1;
    #1;
    check("rst2_score", 32'(score_bcd), 32'h00);
    rst = 1'b0;
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/whack_scorer.md
Name: whack_scorer

Overview:
- Parametrised scoring engine for the whack-a-mole game, generalising the fixed 8-switch, 2-digit scorer.
- Samples N_CH player switches on a down-sampled tick, detects rising edges and qualifies them against the mole LED vector.
- Accumulates hits into an N_DIGITS BCD score that feeds the seven-segment driver.
- Sits between the switch inputs / LED generator and the display mux.

Parameters:
- N_CH, 8, number of switch/LED channels (1..16).
- N_DIGITS, 2, BCD score digits (1..4).
- DS_DIV, 131072, clk cycles per sample tick (>=2).
- CNT_W, $clog2(DS_DIV), width of the tick divider.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pause  in  1  1 = discard hits, score frozen
- clear  in  1  synchronous score clear, single-cycle pulse
- switch  in  N_CH  raw player switches
- led  in  N_CH  current mole LEDs, 1 = mole up
- score_bcd  out  4*N_DIGITS  BCD score, digit 0 in [3:0]
- hit_pulse  out  1  one-cycle pulse when the score is incremented
- hit_vec  out  N_CH  registered qualified-hit vector, valid with hit_pulse
- overflow  out  1  sticky; set on wrap past all-9s

Behaviour:
- Reset (async, rst=1): divider, shift registers, hit_vec, score_bcd, hit_pulse and overflow all 0.
- Tick divider:
  - Counts 0..DS_DIV-1.
  - tick=1 for exactly one cycle when the count equals DS_DIV-1, then the count wraps to 0.
- Per-channel sampler:
  - On tick, 3-bit shift register samp[2:0] <= {switch[c], samp[2:1]}.
  - edge[c] = samp[1] & ~samp[0] (rising edge), evaluated in the cycle after tick (tick_d).
- Hit stage (cycle tick_d):
  - hit_q[c] <= edge[c] & led[c] & ~pause.
  - If !tick_d, hit_q <= 0.
  - led is sampled in this cycle only.
- Score stage (cycle after hit stage):
  - n = popcount(hit_q), range 0..N_CH.
  - score_bcd <= score_bcd + n in BCD, with per-digit carry and decimal adjust.
  - hit_pulse <= (n != 0).
  - hit_vec <= hit_q.
- Latency: switch rising edge captured on tick T → score visible at T+3 clk.
- Simultaneous hits: all counted in one update (e.g. 3 channels → +3). Sequential per-channel increments are not used.
- Wrap: if the sum exceeds 10^N_DIGITS-1, score = sum mod 10^N_DIGITS and overflow <= 1. overflow clears only on rst or clear.
- pause:
  - Sampler keeps running while paused, so holding a switch through pause does not produce a hit on release.
  - Score and overflow hold.
- clear: score_bcd, overflow, hit_vec <= 0 and hit_pulse <= 0. clear wins over a same-cycle increment. Sampler state is untouched.
- Channels with led=0 produce no score change (see optional feature).
- rst mid-pipeline: all pending hits are discarded.

Optional Feature:
- Macro WHACK_MISS_PENALTY_EN.
- Defined:
  - miss_q[c] = edge[c] & ~led[c] & ~pause, registered in parallel with hit_q.
  - Per update, score = score + popcount(hit_q) - popcount(miss_q), saturating at 0 (no borrow wrap).
  - Extra output miss_pulse, 1 bit, one cycle when popcount(miss_q) != 0.
- Undefined: misses are ignored, the miss_pulse port is absent, and the datapath is as above.

Decomposition:
- Package whack_pkg:
  - BCD_DIGIT_W=4, BCD_MAX_DIGIT=4'd9.
  - Function bcd_add (digit-vector + small integer → {carry, digits}).
  - Function bcd_sub_sat.
  - Function popcount.
- Sub-module whack_edge_sampler:
  - Tick divider plus N_CH-wide 3-deep shift registers.
  - Outputs edge[N_CH-1:0] and tick_d.
  - Instantiated once by whack_scorer.

Test Plan:
- Reset/idle: DS_DIV=4, hold rst 3 cycles, then switches static → score_bcd=0, hit_pulse never asserts, overflow=0.
- Single hit: led=8'h04; switch[2] 0→1 held for 3 ticks → exactly one hit_pulse, hit_vec=8'h04, score_bcd=8'h01; no second increment while held.
- Simultaneous hits: score 8'h08, led=8'hFF, switch 8'h00→8'h07 → one hit_pulse, score_bcd=8'h11 (BCD carry).
- Wrap: score 8'h98, two hits in one update → score_bcd=8'h00, overflow=1; clear pulse → overflow=0.
- Pause: pause=1, led=8'hFF, switch[0] rises, pause released 2 ticks later with switch still high → score unchanged, no hit_pulse.
- Miss (with WHACK_MISS_PENALTY_EN): score 8'h00, led=0, switch[5] rises → score stays 8'h00, miss_pulse=1. Score 8'h10, same stimulus → 8'h09.
